uncache_wbuf: RTL and testbench

- Buffers uncached (conf-space) accesses between the bridge's conf port and the AXI controller's uncached request port.
- Stores are posted into a DEPTH-entry FIFO and drained one at a time, so the core does not stall on uncached writes until the FIFO is full.
- Loads wait until the FIFO is empty, then issue a single blocking read. This keeps strict program order for device accesses.

---
 rtl/uncache_wbuf.sv | 174 +++++++++++++++++
 tb/tb_uncache_wbuf.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uncache_wbuf.sv
// Uncached access buffer: posts stores into a small FIFO drained one request at a time,
// and issues loads only once every queued store has completed, so device accesses stay in order.
module uncache_wbuf #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        conf_en,
  input  logic [3:0]  conf_wen,
  input  logic [31:0] conf_addr,
  input  logic [31:0] conf_wdata,
  output logic [31:0] conf_rdata,
  output logic        stallreq,
  output logic        rd_req,
  output logic [31:0] rd_addr,
  output logic        wr_req,
  output logic [3:0]  wr_wstrb,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  input  logic        reload,
  input  logic [31:0] rd_data
);

  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {W_IDLE, W_BUSY} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_BUSY, R_DONE} r_state_e;

  w_state_e         w_state_q, w_state_d;
  r_state_e         r_state_q, r_state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;

  logic [31:0] fifo_addr_q [DEPTH];
  logic [3:0]  fifo_strb_q [DEPTH];
  logic [31:0] fifo_data_q [DEPTH];

  logic        rd_req_q, rd_req_d;
  logic [31:0] rd_addr_q, rd_addr_d;
  logic        wr_req_q, wr_req_d;
  logic [3:0]  wr_wstrb_q, wr_wstrb_d;
  logic [31:0] wr_addr_q, wr_addr_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic [31:0] conf_rdata_q, conf_rdata_d;

  logic is_wr, is_rd, full, empty;
  logic push, pop, w_start, r_start, r_finish;

  assign is_wr = conf_en && (conf_wen != 4'b0000);
  assign is_rd = conf_en && (conf_wen == 4'b0000);
  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

  // Push needs a free slot at cycle start; a same-cycle pop never frees room for it.
  assign push     = is_wr && !full && (r_state_q == R_IDLE);
  assign pop      = (w_state_q == W_BUSY) && reload;
  assign w_start  = (w_state_q == W_IDLE) && !empty && (r_state_q == R_IDLE);
  assign r_start  = (r_state_q == R_IDLE) && is_rd && empty && (w_state_q == W_IDLE);
  assign r_finish = (r_state_q == R_BUSY) && reload;

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) begin
      w_state_q    <= W_IDLE;
      r_state_q    <= R_IDLE;
      count_q      <= '0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      rd_req_q     <= 1'b0;
      rd_addr_q    <= '0;
      wr_req_q     <= 1'b0;
      wr_wstrb_q   <= '0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      conf_rdata_q <= '0;
    end else begin
      w_state_q    <= w_state_d;
      r_state_q    <= r_state_d;
      count_q      <= count_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      rd_req_q     <= rd_req_d;
      rd_addr_q    <= rd_addr_d;
      wr_req_q     <= wr_req_d;
      wr_wstrb_q   <= wr_wstrb_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      conf_rdata_q <= conf_rdata_d;
    end
  end

  // Entry storage carries no reset; count alone says which slots are live.
  always_ff @(posedge clk) begin
    if (resetn && push) begin
      fifo_addr_q[wptr_q] <= conf_addr;
      fifo_strb_q[wptr_q] <= conf_wen;
      fifo_data_q[wptr_q] <= conf_wdata;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_d = w_state_q;
    r_state_d = r_state_q;
    case (w_state_q)
      W_IDLE:  if (w_start) w_state_d = W_BUSY;
      W_BUSY:  if (reload)  w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
    case (r_state_q)
      R_IDLE:  if (r_start) r_state_d = R_BUSY;
      R_BUSY:  if (reload)  r_state_d = R_DONE;
      R_DONE:  r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  // Output and datapath logic
  always_comb begin
    count_d      = count_q;
    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    rd_req_d     = rd_req_q;
    rd_addr_d    = rd_addr_q;
    wr_req_d     = wr_req_q;
    wr_wstrb_d   = wr_wstrb_q;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    conf_rdata_d = conf_rdata_q;

    if (push) wptr_d = wptr_q + PTR_W'(1);
    if (pop)  rptr_d = rptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (w_start) begin
      wr_req_d   = 1'b1;
      wr_addr_d  = fifo_addr_q[rptr_q];
      wr_wstrb_d = fifo_strb_q[rptr_q];
      wr_data_d  = fifo_data_q[rptr_q];
    end else if (pop) begin
      wr_req_d = 1'b0;
    end

    if (r_start) begin
      rd_req_d  = 1'b1;
      rd_addr_d = conf_addr;
    end else if (r_finish) begin
      rd_req_d     = 1'b0;
      conf_rdata_d = rd_data;
    end
  end

  // A read sees stallreq drop only in R_DONE, the cycle conf_rdata is handed over.
  always_comb begin
    stallreq = 1'b0;
    if (is_wr && (full || (r_state_q != R_IDLE))) stallreq = 1'b1;
    if (is_rd && ((r_state_q == R_IDLE) || (r_state_q == R_BUSY))) stallreq = 1'b1;
  end

  assign conf_rdata = conf_rdata_q;
  assign rd_req     = rd_req_q;
  assign rd_addr    = rd_addr_q;
  assign wr_req     = wr_req_q;
  assign wr_wstrb   = wr_wstrb_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;

endmodule

// File: tb/tb_uncache_wbuf.sv
// Directed bench for uncache_wbuf: a core-side driver, a reload responder that logs every
// AXI request, and hand-computed expectations for write posting, read ordering and reset.
module tb_uncache_wbuf;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        conf_en = 1'b0;
  logic [3:0]  conf_wen = 4'h0;
  logic [31:0] conf_addr = '0;
  logic [31:0] conf_wdata = '0;
  logic [31:0] conf_rdata;
  logic        stallreq;
  logic        rd_req;
  logic [31:0] rd_addr;
  logic        wr_req;
  logic [3:0]  wr_wstrb;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        reload = 1'b0;
  logic [31:0] rd_data = '0;

  uncache_wbuf #(.DEPTH(4), .PTR_W(2)) dut (
    .clk(clk), .resetn(resetn),
    .conf_en(conf_en), .conf_wen(conf_wen), .conf_addr(conf_addr), .conf_wdata(conf_wdata),
    .conf_rdata(conf_rdata), .stallreq(stallreq),
    .rd_req(rd_req), .rd_addr(rd_addr),
    .wr_req(wr_req), .wr_wstrb(wr_wstrb), .wr_addr(wr_addr), .wr_data(wr_data),
    .reload(reload), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Responder: answers each request resp_lat cycles after it is seen, logs it.
  bit          resp_en = 1'b0;
  int          resp_lat = 0;
  int          stray_req = 0;
  int          stray_done = 0;
  logic [31:0] rd_val = '0;
  logic [31:0] wlog_addr [$];
  logic [31:0] wlog_data [$];
  logic [3:0]  wlog_strb [$];
  logic [31:0] rlog_addr [$];
  int          kind_log [$];

  always begin
    @(negedge clk);
    if (stray_req != stray_done) begin
      stray_done++;
      reload = 1'b1;
      @(negedge clk);
      reload = 1'b0;
    end else if (resp_en && resetn && (wr_req || rd_req)) begin
      if (wr_req) begin
        wlog_addr.push_back(wr_addr);
        wlog_data.push_back(wr_data);
        wlog_strb.push_back(wr_wstrb);
        kind_log.push_back(0);
        $display("[%0t] wr addr=%h strb=%h data=%h", $time, wr_addr, wr_wstrb, wr_data);
      end else begin
        rlog_addr.push_back(rd_addr);
        kind_log.push_back(1);
        $display("[%0t] rd addr=%h data=%h", $time, rd_addr, rd_val);
      end
      repeat (resp_lat) @(negedge clk);
      rd_data = rd_val;
      reload = 1'b1;
      @(negedge clk);
      reload = 1'b0;
    end
  end

  // Ordering monitor: no overlapping requests, no read while stores are queued.
  int viol = 0;
  always @(negedge clk) begin
    if (resetn) begin
      if (wr_req && rd_req) viol++;
      if (rd_req && (dut.count_q != 0)) viol++;
    end
  end

  task automatic cpu_write(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d,
                           output int stalls);
    conf_en = 1'b1; conf_wen = w; conf_addr = a; conf_wdata = d;
    stalls = 0;
    forever begin
      @(negedge clk);
      if (!stallreq) break;
      stalls++;
      if (stalls >= 500) begin
        check("cpu_write_timeout", 1, 0);
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    conf_en = 1'b0; conf_wen = 4'h0;
  endtask

  task automatic cpu_read(input logic [31:0] a, output logic [31:0] d, output int stalls);
    conf_en = 1'b1; conf_wen = 4'h0; conf_addr = a;
    stalls = 0;
    forever begin
      @(negedge clk);
      if (!stallreq) break;
      stalls++;
      if (stalls >= 500) begin
        check("cpu_read_timeout", 1, 0);
        break;
      end
      @(posedge clk); #1;
    end
    d = conf_rdata;
    @(posedge clk); #1;
    conf_en = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (dut.count_q == 0 && !wr_req && !rd_req) begin
        ok = 1'b1;
        break;
      end
    end
    check(tag, ok, 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          st;
    int          base;
    int          kbase;
    logic [31:0] d;
    logic [31:0] exp_a [10];
    logic [31:0] exp_d [10];
    logic [3:0]  exp_s [10];

    // Reset state
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    check("rst_wr_req", wr_req, 0);
    check("rst_rd_req", rd_req, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_rdata", conf_rdata, 0);
    check("rst_count", dut.count_q, 0);
    check("rst_stall", stallreq, 0);

    // Single write, reload 3 cycles after wr_req
    resp_en = 1'b1; resp_lat = 3;
    @(posedge clk); #1;
    conf_en = 1'b1; conf_wen = 4'hF; conf_addr = 32'hBFAF_F000; conf_wdata = 32'h1234_5678;
    @(negedge clk);
    check("w1_stall", stallreq, 0);
    @(posedge clk); #1;
    conf_en = 1'b0; conf_wen = 4'h0;
    @(negedge clk);
    check("w1_req_early", wr_req, 0);
    @(negedge clk);
    check("w1_req", wr_req, 1);
    check("w1_addr", wr_addr, 32'hBFAF_F000);
    check("w1_data", wr_data, 32'h1234_5678);
    check("w1_strb", wr_wstrb, 4'hF);
    repeat (3) @(negedge clk);
    check("w1_req_held", wr_req, 1);
    @(negedge clk);
    check("w1_req_drop", wr_req, 0);
    check("w1_count", dut.count_q, 0);

    // Fill and overflow, reload held low
    resp_en = 1'b0;
    base = wlog_addr.size();
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      cpu_write(32'hBFAF_F100 + 32'(i * 4), 4'hF, 32'h1111_0000 + 32'(i), st);
      check($sformatf("fill_stall%0d", i), st, 0);
    end
    conf_en = 1'b1; conf_wen = 4'hF; conf_addr = 32'hBFAF_F110; conf_wdata = 32'h1111_0004;
    @(negedge clk);
    check("fill5_stall_a", stallreq, 1);
    check("fill_full", dut.count_q, 4);
    @(posedge clk); #1;
    @(negedge clk);
    check("fill5_stall_b", stallreq, 1);
    @(posedge clk); #1;
    resp_en = 1'b1; resp_lat = 0;
    @(negedge clk);
    check("fill5_stall_reload", stallreq, 1);
    @(posedge clk); #1;
    @(negedge clk);
    check("fill5_accept", stallreq, 0);
    check("fill5_count", dut.count_q, 3);
    @(posedge clk); #1;
    conf_en = 1'b0; conf_wen = 4'h0;
    wait_idle("fill_drain");
    check("fill_nlog", wlog_addr.size() - base, 5);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("fill_order_a%0d", i), wlog_addr[base + i], 32'hBFAF_F100 + 32'(i * 4));
      check($sformatf("fill_order_d%0d", i), wlog_data[base + i], 32'h1111_0000 + 32'(i));
    end

    // Read after two queued writes
    resp_lat = 2;
    rd_val = 32'hDEAD_BEEF;
    kbase = kind_log.size();
    base = wlog_addr.size();
    cpu_write(32'hBFAF_F200, 4'hF, 32'hAAAA_0001, st);
    cpu_write(32'hBFAF_F204, 4'hF, 32'hAAAA_0002, st);
    cpu_read(32'hBFAF_F008, d, st);
    check("rd_stalled", (st > 0), 1);
    check("rd_data", d, 32'hDEAD_BEEF);
    check("rd_order_n", kind_log.size() - kbase, 3);
    check("rd_order_k0", kind_log[kbase], 0);
    check("rd_order_k1", kind_log[kbase + 1], 0);
    check("rd_order_k2", kind_log[kbase + 2], 1);
    check("rd_w2_addr", wlog_addr[base + 1], 32'hBFAF_F204);
    check("rd_addr", rlog_addr[rlog_addr.size() - 1], 32'hBFAF_F008);
    repeat (3) @(posedge clk);
    #1;
    check("rd_hold", conf_rdata, 32'hDEAD_BEEF);

    // Write issued while the read is outstanding
    resp_lat = 4;
    rd_val = 32'hCAFE_F00D;
    conf_en = 1'b1; conf_wen = 4'h0; conf_addr = 32'hBFAF_F00C;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rd_req) break;
      @(posedge clk); #1;
    end
    check("rw_rd_req", rd_req, 1);
    base = wlog_addr.size();
    @(posedge clk); #1;
    cpu_write(32'hBFAF_F300, 4'h3, 32'h0000_5A5A, st);
    check("rw_stalls", st, 5);
    check("rw_no_wr_yet", wlog_addr.size() - base, 0);
    check("rw_rdata", conf_rdata, 32'hCAFE_F00D);
    wait_idle("rw_drain");
    check("rw_nlog", wlog_addr.size() - base, 1);
    check("rw_addr", wlog_addr[wlog_addr.size() - 1], 32'hBFAF_F300);
    check("rw_strb", wlog_strb[wlog_strb.size() - 1], 4'h3);
    check("rw_data", wlog_data[wlog_data.size() - 1], 32'h0000_5A5A);

    // Reset with writes queued and one in flight
    resp_en = 1'b0;
    for (int i = 0; i < 3; i++) cpu_write(32'hBFAF_F400 + 32'(i * 4), 4'hF, 32'h4444_0000 + 32'(i), st);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (wr_req) break;
    end
    check("mr_wr_req", wr_req, 1);
    @(posedge clk); #1;
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    @(negedge clk);
    check("mr_wr_req0", wr_req, 0);
    check("mr_rd_req0", rd_req, 0);
    check("mr_count", dut.count_q, 0);
    check("mr_wr_addr", wr_addr, 0);
    check("mr_wr_data", wr_data, 0);
    check("mr_wr_strb", wr_wstrb, 0);
    check("mr_rd_addr", rd_addr, 0);
    check("mr_rdata", conf_rdata, 0);
    stray_req++;
    repeat (4) @(negedge clk);
    check("mr_stray_count", dut.count_q, 0);
    check("mr_stray_rptr", dut.rptr_q, 0);
    check("mr_stray_wr_req", wr_req, 0);

    // Pointer wrap: ten writes, reload two cycles after each request
    resp_en = 1'b1; resp_lat = 2;
    base = wlog_addr.size();
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      exp_a[i] = 32'hA000_0000 + 32'(i * 16);
      exp_d[i] = 32'h0BAD_0000 ^ (32'(i) * 32'h0101_0101);
      exp_s[i] = 4'((i % 15) + 1);
      cpu_write(exp_a[i], exp_s[i], exp_d[i], st);
    end
    wait_idle("wrap_drain");
    check("wrap_nlog", wlog_addr.size() - base, 10);
    for (int i = 0; i < 10; i++) begin
      if (base + i < wlog_addr.size()) begin
        check($sformatf("wrap_a%0d", i), wlog_addr[base + i], exp_a[i]);
        check($sformatf("wrap_d%0d", i), wlog_data[base + i], exp_d[i]);
        check($sformatf("wrap_s%0d", i), wlog_strb[base + i], exp_s[i]);
      end
    end

    check("order_violations", viol, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
